alu_stream: RTL and testbench
=============================

ALU_STREAM -- requirements
Module: alu_stream

Interface
- REQ-001 XLEN, 32, operand and result width; legal values 32 or 64.
- REQ-002 TAG_W, 4, width of the caller tag carried alongside each operation.
- REQ-003 FIFO_DEPTH, 4, result-buffer entries; a power of two, at least 2.
- REQ-004 soc_clk  in  1  the single clock; all state updates on its rising edge.
- REQ-005 reset_n  in  1  asynchronous, active-low reset.
- REQ-006 in_valid  in  1  operation request present.
- REQ-007 in_ready  out  1  block can accept a request this cycle.
- REQ-008 in_op  in  5  operation code (encoding in REQ-015).
- REQ-009 in_dat1 / in_dat2  in  XLEN each  operands A and B.
- REQ-010 in_tag  in  TAG_W  opaque tag, returned unchanged with the result.
- REQ-011 flush  in  1  synchronous discard of all in-flight and buffered results.
- REQ-012 out_valid  out  1  result present at the buffer head.
- REQ-013 out_ready  in  1  consumer takes the head result.
- REQ-014 out_res (XLEN), out_tag (TAG_W), out_overflow, out_con_met, out_zero, out_err (1 each)  out  result and flags; count  out  $clog2(FIFO_DEPTH)+1  buffered entries.

Function
- REQ-015 Op encoding:
  - 0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU;
  - 6 ADD, 7 SUB, 8 SLL, 9 SLT, 10 SLTU, 11 XOR, 12 SRL, 13 SRA, 14 OR, 15 AND;
  - 16-31 are invalid.
- REQ-016 Handshake:
  - a request is accepted on a rising edge where in_valid and in_ready are both 1;
  - out_valid and its payload stay stable until out_valid and out_ready are both 1.
- REQ-017 Pipeline:
  - stage S1 registers the operands, op and tag on accept;
  - on the next edge the result is computed from S1 and pushed into the result FIFO.
- REQ-018 Latency: a result accepted at edge k appears at out_valid after edge k+1 when the FIFO was empty; otherwise it appears behind older entries in strict issue order.
- REQ-019 Throughput: one accept per cycle while in_ready is 1.
- REQ-020 in_ready = (count + S1_valid < FIFO_DEPTH) and not flush; it is registered-state only, with no combinational path from out_ready.
- REQ-021 A simultaneous push and pop leaves count unchanged; FIFO pointers wrap modulo FIFO_DEPTH.
- REQ-022 Arithmetic:
  - ADD and SUB are modulo 2^XLEN;
  - shifts use the low $clog2(XLEN) bits of B;
  - SRA replicates A[XLEN-1];
  - SLT and SLTU return 0 or 1 zero-extended.
- REQ-023 Overflow: out_overflow is the signed overflow for ADD/SUB and 0 for all other ops.
- REQ-024 Branch ops:
  - out_con_met is the condition (signed compare for BLT/BGE, unsigned for BLTU/BGEU);
  - out_res = zero-extended con_met;
  - out_con_met is 0 for non-branch ops.
- REQ-025 out_zero = (out_res == 0) for every op, including invalid ops.
- REQ-026 Invalid op: out_err = 1, out_res = 0, other flags 0; the result is still buffered and the tag still returned.
- REQ-027 Flush:
  - on a flush edge, S1_valid and count go to 0 and out_valid drops;
  - flush overrides a simultaneous accept or pop, since in_ready is 0 during flush;
  - requests resume being accepted on the following cycle.
- REQ-028 Full buffer with out_ready = 0: no entry is lost or overwritten; the S1 result always has a reserved slot.
- REQ-029 When out_valid is 0: out_res, out_tag and flags are 0.

Reset
- REQ-030 Assertion of reset_n = 0 immediately clears S1_valid, FIFO pointers and count.
- REQ-031 During reset, and in the first cycle after reset_n rises: in_ready = 1, out_valid = 0, all out_* = 0, count = 0.
- REQ-032 Reset mid-operation discards all in-flight and buffered results; no stale result is emitted after release.

Verification
- REQ-033 ADD A=0x7FFFFFFF, B=0x1, tag=3, out_ready=1 -> out_valid 2 cycles after accept; out_res=0x80000000, overflow=1, zero=0, out_tag=3.
- REQ-034 out_ready=0, issue tags 0..5 back-to-back -> 4 accepted, in_ready=0, count=3 then 4; then out_ready=1 -> tags 0,1,2,3 in order, then tags 4,5 accepted and returned.
- REQ-035 Branches:
  - BLT A=0xFFFFFFFD, B=0 -> con_met=1, res=1, zero=0;
  - BGEU A=3, B=5 -> con_met=0, res=0, zero=1.
- REQ-036 SRA A=0xF0000000, B=0x24 -> res=0xFF000000 (shamt 4); SRL with the same operands -> 0x0F000000.
- REQ-037 op=20, A=5, B=3, tag=7 -> err=1, res=0, zero=1, tag=7.
- REQ-038 Flush and reset with 3 buffered plus 1 in S1:
  - flush -> count=0 next cycle, no outputs;
  - repeat, then pull reset_n low mid-cycle -> outputs clear asynchronously;
  - the first op after release returns correctly.

Source files
------------

// File: rtl/alu_stream.sv
// Streaming integer ALU. A request is registered in S1, evaluated on the next
// edge and queued in an in-order result FIFO with a valid/ready output port.
module alu_stream #(
  parameter int XLEN       = 32,
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          soc_clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [4:0]                    in_op,
  input  logic [XLEN-1:0]               in_dat1,
  input  logic [XLEN-1:0]               in_dat2,
  input  logic [TAG_W-1:0]              in_tag,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               out_res,
  output logic [TAG_W-1:0]              out_tag,
  output logic                          out_overflow,
  output logic                          out_con_met,
  output logic                          out_zero,
  output logic                          out_err,
  output logic [$clog2(FIFO_DEPTH):0]   count
);
  localparam int SHW = $clog2(XLEN);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int M   = XLEN - 1;

  typedef struct packed {
    logic [4:0]       op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
    logic             ovf;
    logic             con;
    logic             zero;
    logic             err;
  } rsp_t;

  req_t            s1;
  logic            s1_valid;
  rsp_t            alu;
  rsp_t            mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            accept, push, pop;
  logic [SHW-1:0]  shamt;
  logic            lt_s, lt_u;

  // S1 always owns a slot: occupancy counts the buffered entries plus S1.
  assign in_ready  = ((CW+1)'(count) + (CW+1)'(s1_valid) < (CW+1)'(FIFO_DEPTH)) && !flush;
  assign accept    = in_valid && in_ready;
  assign push      = s1_valid;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;

  always_ff @(posedge soc_clk or negedge reset_n) begin
    if (!reset_n)   s1_valid <= 1'b0;
    else if (flush) s1_valid <= 1'b0;
    else            s1_valid <= accept;
  end

  always_ff @(posedge soc_clk) begin
    if (accept) s1 <= '{op: in_op, a: in_dat1, b: in_dat2, tag: in_tag};
  end

  assign shamt = s1.b[SHW-1:0];
  assign lt_s  = $signed(s1.a) < $signed(s1.b);
  assign lt_u  = s1.a < s1.b;

  always_comb begin
    alu     = '0;
    alu.tag = s1.tag;
    case (s1.op)
      5'd0:  alu.con = (s1.a == s1.b);
      5'd1:  alu.con = (s1.a != s1.b);
      5'd2:  alu.con = lt_s;
      5'd3:  alu.con = !lt_s;
      5'd4:  alu.con = lt_u;
      5'd5:  alu.con = !lt_u;
      5'd6: begin
        alu.res = s1.a + s1.b;
        alu.ovf = (s1.a[M] == s1.b[M]) && (alu.res[M] != s1.a[M]);
      end
      5'd7: begin
        alu.res = s1.a - s1.b;
        alu.ovf = (s1.a[M] != s1.b[M]) && (alu.res[M] != s1.a[M]);
      end
      5'd8:  alu.res = s1.a << shamt;
      5'd9:  alu.res = XLEN'(lt_s);
      5'd10: alu.res = XLEN'(lt_u);
      5'd11: alu.res = s1.a ^ s1.b;
      5'd12: alu.res = s1.a >> shamt;
      5'd13: alu.res = $signed(s1.a) >>> shamt;
      5'd14: alu.res = s1.a | s1.b;
      5'd15: alu.res = s1.a & s1.b;
      default: alu.err = 1'b1;
    endcase
    if (s1.op < 5'd6) alu.res = XLEN'(alu.con);
    alu.zero = (alu.res == '0);
  end

  always_ff @(posedge soc_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge soc_clk) begin
    if (push && !flush) mem[wr_ptr] <= alu;
  end

  // Payload is forced to zero whenever the head is empty.
  assign out_res      = out_valid ? mem[rd_ptr].res  : '0;
  assign out_tag      = out_valid ? mem[rd_ptr].tag  : '0;
  assign out_overflow = out_valid && mem[rd_ptr].ovf;
  assign out_con_met  = out_valid && mem[rd_ptr].con;
  assign out_zero     = out_valid && mem[rd_ptr].zero;
  assign out_err      = out_valid && mem[rd_ptr].err;
endmodule

// File: tb/tb_alu_stream.sv
// Bench for alu_stream: directed spec cases plus random traffic, checked
// against a queue-based reference model of the S1 stage and result buffer.
module tb_alu_stream;
  logic        soc_clk = 1'b0, reset_n = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [4:0]  in_op = '0;
  logic [31:0] in_dat1 = '0, in_dat2 = '0;
  logic [3:0]  in_tag = '0;
  logic        in_ready, out_valid, out_overflow, out_con_met, out_zero, out_err;
  logic [31:0] out_res;
  logic [3:0]  out_tag;
  logic [2:0]  count;

  alu_stream #(.XLEN(32), .TAG_W(4), .FIFO_DEPTH(4)) dut (
    .soc_clk(soc_clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_dat1(in_dat1), .in_dat2(in_dat2), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_tag(out_tag),
    .out_overflow(out_overflow), .out_con_met(out_con_met), .out_zero(out_zero),
    .out_err(out_err), .count(count));

  always #5 soc_clk = ~soc_clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    logic        ovf, con, zero, err;
  } exp_t;

  int          n_assert = 0, n_fail = 0;
  exp_t        fq[$];
  exp_t        s1_item;
  bit          s1_has = 1'b0;
  logic [3:0]  popped[$];

  function automatic exp_t ref_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] tag);
    exp_t   e;
    longint sa, sb, ua, ub, s;
    int     sh;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'(a);          ub = longint'(b);
    sh = int'(b % 32);
    e = '{res: '0, tag: tag, ovf: 1'b0, con: 1'b0, zero: 1'b0, err: 1'b0};
    case (op)
      0: e.con = (ua == ub);
      1: e.con = (ua != ub);
      2: e.con = (sa < sb);
      3: e.con = (sa >= sb);
      4: e.con = (ua < ub);
      5: e.con = (ua >= ub);
      6, 7: begin
        s = (op == 6) ? sa + sb : sa - sb;
        e.res = s[31:0];
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      8:  begin s = ua << sh; e.res = s[31:0]; end
      9:  e.res = {31'd0, sa < sb};
      10: e.res = {31'd0, ua < ub};
      11: e.res = a ^ b;
      12: begin s = ua >> sh; e.res = s[31:0]; end
      13: begin s = sa >>> sh; e.res = s[31:0]; end
      14: e.res = a | b;
      15: e.res = a & b;
      default: e.err = 1'b1;
    endcase
    if (op < 6) e.res = {31'd0, e.con};
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag);
    in_valid = v; in_op = op; in_dat1 = a; in_dat2 = b; in_tag = tag;
  endtask

  // One clock: check the DUT against the model at the falling edge, then
  // advance the model across the rising edge.
  task automatic cyc();
    exp_t h, nx;
    bit   exp_rdy, acc;
    @(negedge soc_clk);
    exp_rdy = ((fq.size() + int'(s1_has)) < 4) && !flush;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("count", 64'(count), 64'(fq.size()));
    chk("out_valid", 64'(out_valid), 64'(fq.size() != 0));
    if (fq.size() == 0)
      chk("idle_out", 64'({out_res, out_tag, out_overflow, out_con_met, out_zero, out_err}), 64'd0);
    else if (out_ready && !flush) begin
      h = fq.pop_front();
      popped.push_back(h.tag);
      chk("res", 64'(out_res), 64'(h.res));
      chk("tag", 64'(out_tag), 64'(h.tag));
      chk("flags", 64'({out_overflow, out_con_met, out_zero, out_err}),
          64'({h.ovf, h.con, h.zero, h.err}));
    end
    acc = in_valid && exp_rdy;
    nx  = ref_op(in_op, in_dat1, in_dat2, in_tag);
    @(posedge soc_clk);
    if (flush) begin
      fq.delete();
      s1_has = 1'b0;
    end else begin
      if (s1_has) fq.push_back(s1_item);
      s1_has  = acc;
      s1_item = nx;
    end
    #1;
  endtask

  // Single op into an empty buffer; explicit spec constants checked while held.
  task automatic dir(input string nm, input logic [4:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [3:0] tag,
                     input logic [31:0] er, input logic [3:0] ef);
    out_ready = 1'b0;
    drive(1'b1, op, a, b, tag); cyc();
    in_valid = 1'b0;
    chk({nm, "_lat1"}, 64'(out_valid), 64'd0);
    cyc();
    chk({nm, "_lat2"}, 64'(out_valid), 64'd1);
    chk({nm, "_res"}, 64'(out_res), 64'(er));
    chk({nm, "_tag"}, 64'(out_tag), 64'(tag));
    chk({nm, "_flags"}, 64'({out_overflow, out_con_met, out_zero, out_err}), 64'(ef));
    cyc();
    out_ready = 1'b1; cyc();
  endtask

  initial begin
    int sent, guard;
    bit acc;
    // Reset state, checked while reset is asserted
    #3;
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out", 64'({out_res, out_tag, out_overflow, out_con_met, out_zero, out_err}), 64'd0);
    #9 reset_n = 1'b1;
    @(posedge soc_clk); #1;
    cyc();

    // Directed spec cases (flags = {ovf, con_met, zero, err})
    dir("add_ovf", 5'd6,  32'h7FFF_FFFF, 32'h1,  4'd3, 32'h8000_0000, 4'b1000);
    dir("sub_ovf", 5'd7,  32'h8000_0000, 32'h1,  4'd9, 32'h7FFF_FFFF, 4'b1000);
    dir("blt",     5'd2,  32'hFFFF_FFFD, 32'h0,  4'd1, 32'h1,         4'b0100);
    dir("bgeu",    5'd5,  32'h3,         32'h5,  4'd2, 32'h0,         4'b0010);
    dir("sra",     5'd13, 32'hF000_0000, 32'h24, 4'd4, 32'hFF00_0000, 4'b0000);
    dir("srl",     5'd12, 32'hF000_0000, 32'h24, 4'd5, 32'h0F00_0000, 4'b0000);
    dir("inval",   5'd20, 32'h5,         32'h3,  4'd7, 32'h0,         4'b0011);

    // Backpressure: tags 0..5 back-to-back with out_ready low
    out_ready = 1'b0;
    popped.delete();
    for (int t = 0; t < 4; t++) begin
      drive(1'b1, 5'd6, 32'(t), 32'd100, 4'(t)); cyc();
    end
    chk("bp_cnt3", 64'(count), 64'd3);
    chk("bp_rdy0", 64'(in_ready), 64'd0);
    drive(1'b1, 5'd6, 32'd4, 32'd100, 4'd4); cyc();
    chk("bp_cnt4", 64'(count), 64'd4);
    chk("bp_rdy0b", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    sent = 4; guard = 0;
    while ((sent < 6 || fq.size() != 0 || s1_has) && guard < 40) begin
      if (sent < 6) drive(1'b1, 5'd6, 32'(sent), 32'd100, 4'(sent));
      else in_valid = 1'b0;
      acc = in_valid && in_ready;
      cyc();
      if (acc) sent++;
      guard++;
    end
    in_valid = 1'b0;
    chk("bp_drain", 64'(guard < 40), 64'd1);
    chk("bp_npop", 64'(popped.size()), 64'd6);
    for (int i = 0; i < 6 && i < popped.size(); i++) chk("bp_order", 64'(popped[i]), 64'(i));

    // Random traffic including invalid ops, backpressure and flushes
    for (int n = 0; n < 400; n++) begin
      logic [4:0] op;
      op = (($urandom % 8) == 0) ? 5'(16 + $urandom % 16) : 5'($urandom % 16);
      drive((($urandom % 4) != 0), op,
            (($urandom % 6) == 0) ? 32'h7FFF_FFFF : $urandom,
            (($urandom % 6) == 0) ? 32'h8000_0000 : $urandom, 4'($urandom));
      out_ready = (($urandom % 3) != 0);
      flush     = (($urandom % 40) == 0);
      cyc();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) cyc();

    // Flush with 3 buffered plus 1 in S1
    out_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      drive(1'b1, 5'd15, $urandom, $urandom, 4'(t)); cyc();
    end
    in_valid = 1'b0;
    chk("fl_pre", 64'(count), 64'd3);
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    cyc();
    dir("post_fl", 5'd11, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'd6, 32'hF00F_F00F, 4'b0000);

    // Reset asserted mid-cycle with the same occupancy
    out_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      drive(1'b1, 5'd14, $urandom, $urandom, 4'(t)); cyc();
    end
    in_valid = 1'b0;
    chk("rs_pre", 64'(count), 64'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("rs_valid", 64'(out_valid), 64'd0);
    chk("rs_count", 64'(count), 64'd0);
    chk("rs_ready", 64'(in_ready), 64'd1);
    chk("rs_out", 64'({out_res, out_tag, out_overflow, out_con_met, out_zero, out_err}), 64'd0);
    fq.delete(); s1_has = 1'b0;
    @(negedge soc_clk); #2 reset_n = 1'b1;
    cyc();
    dir("post_rst", 5'd6, 32'd5, 32'd7, 4'd8, 32'd12, 4'b0000);
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
